osc_pulse_gen: RTL

Multi-channel programmable pulse/oscillator generator for DAQ trigger, marker and heartbeat outputs. Each of `NUM_CH` independent channels produces a square wave with programmable high time, low time, output polarity and burst length (continuous or N periods). Configuration changes to a running channel are held in a shadow register and applied glitch-free at the next period boundary. Outputs are registered and can drive fabric or output pins directly.

---
 rtl/osc_pulse_gen.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/osc_pulse_gen.sv
// osc_pulse_gen
// Multi-channel programmable square-wave / pulse generator. Each channel runs
// an independent IDLE/HIGH/LOW state machine producing H cycles high followed
// by L cycles low, repeated continuously or for a programmed number of periods.
// Configuration written while a channel is running is held in a shadow
// (pending) register and applied at the next LOW->HIGH boundary or on return
// to IDLE, so a period in flight is never distorted.
//
// Ports
//   clk        : single clock
//   rst        : asynchronous, active-high reset
//   cfg_valid  : config write strobe (one write per cycle)
//   cfg_ch     : target channel; values >= NUM_CH are ignored
//   cfg_high   : high-phase length in cycles (0 treated as 1)
//   cfg_low    : low-phase length in cycles (0 treated as 1)
//   cfg_bursts : periods per run, 0 = continuous
//   cfg_invert : invert channel output, including idle level
//   start      : per-channel run request, level sampled
//   stop       : per-channel abort, level sampled, wins over start
//   sig_out    : registered waveform outputs
//   busy       : channel is in HIGH or LOW
//   done       : one-cycle pulse when a burst completes normally
//
// Handshake: cfg_valid is a single-cycle strobe with no back-pressure; every
// write with a valid channel number is accepted on the edge it is sampled.
// start/stop are plain levels evaluated at every edge.
//
// The per-channel state register is visible hierarchically as
// g_ch[n].r_state for checkers.

module osc_pulse_gen #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        cfg_valid,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [CNT_W-1:0]                            cfg_high,
    input  logic [CNT_W-1:0]                            cfg_low,
    input  logic [BURST_W-1:0]                          cfg_bursts,
    input  logic                                        cfg_invert,
    input  logic [NUM_CH-1:0]                           start,
    input  logic [NUM_CH-1:0]                           stop,
    output logic [NUM_CH-1:0]                           sig_out,
    output logic [NUM_CH-1:0]                           busy,
    output logic [NUM_CH-1:0]                           done
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    // Phase lengths are clamped once here; channels only ever store values >= 1,
    // which keeps the "length - 1" timer loads from underflowing.
    logic [CNT_W-1:0] w_cfg_high_c;
    logic [CNT_W-1:0] w_cfg_low_c;

    assign w_cfg_high_c = (cfg_high == '0) ? CNT_W'(1) : cfg_high;
    assign w_cfg_low_c  = (cfg_low  == '0) ? CNT_W'(1) : cfg_low;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        state_t             r_state,      w_state_nx;
        logic [CNT_W-1:0]   r_timer,      w_timer_nx;
        logic [BURST_W-1:0] r_pcnt,       w_pcnt_nx;
        logic [BURST_W-1:0] r_run_bursts, w_run_bursts_nx;
        logic [CNT_W-1:0]   r_act_high,   w_act_high_nx;
        logic [CNT_W-1:0]   r_act_low,    w_act_low_nx;
        logic [BURST_W-1:0] r_act_bursts, w_act_bursts_nx;
        logic               r_act_inv,    w_act_inv_nx;
        logic [CNT_W-1:0]   r_pend_high,  w_pend_high_nx;
        logic [CNT_W-1:0]   r_pend_low,   w_pend_low_nx;
        logic               r_pend_inv,   w_pend_inv_nx;
        logic               r_pend,       w_pend_nx;
        logic               r_sig;
        logic               r_done,       w_done_nx;
        logic               w_wr;
        logic               w_period_end;
        logic [BURST_W-1:0] w_pcnt_inc;

        assign w_wr       = cfg_valid && (cfg_ch == CH_W'(gi));
        assign w_pcnt_inc = r_pcnt + BURST_W'(1);

        always_comb begin
            w_state_nx      = r_state;
            w_timer_nx      = r_timer;
            w_pcnt_nx       = r_pcnt;
            w_run_bursts_nx = r_run_bursts;
            w_act_high_nx   = r_act_high;
            w_act_low_nx    = r_act_low;
            w_act_bursts_nx = r_act_bursts;
            w_act_inv_nx    = r_act_inv;
            w_pend_high_nx  = r_pend_high;
            w_pend_low_nx   = r_pend_low;
            w_pend_inv_nx   = r_pend_inv;
            w_pend_nx       = r_pend;
            w_done_nx       = 1'b0;
            w_period_end    = 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_wr) begin
                        w_act_high_nx   = w_cfg_high_c;
                        w_act_low_nx    = w_cfg_low_c;
                        w_act_bursts_nx = cfg_bursts;
                        w_act_inv_nx    = cfg_invert;
                    end
                    // A write and a start on the same edge run with the new values.
                    if (start[gi] && !stop[gi]) begin
                        w_state_nx      = ST_HIGH;
                        w_timer_nx      = w_act_high_nx - CNT_W'(1);
                        w_pcnt_nx       = '0;
                        w_run_bursts_nx = w_act_bursts_nx;
                    end
                end
                ST_HIGH: begin
                    if (stop[gi]) begin
                        w_state_nx = ST_IDLE;
                        w_timer_nx = '0;
                    end else if (r_timer == '0) begin
                        w_state_nx = ST_LOW;
                        w_timer_nx = r_act_low - CNT_W'(1);
                    end else begin
                        w_timer_nx = r_timer - CNT_W'(1);
                    end
                end
                ST_LOW: begin
                    if (stop[gi]) begin
                        w_state_nx = ST_IDLE;
                        w_timer_nx = '0;
                    end else if (r_timer == '0) begin
                        w_pcnt_nx = w_pcnt_inc;
                        if ((r_run_bursts != '0) && (w_pcnt_inc == r_run_bursts)) begin
                            w_state_nx = ST_IDLE;
                            w_done_nx  = 1'b1;
                        end else begin
                            w_state_nx   = ST_HIGH;
                            w_period_end = 1'b1;
                        end
                    end else begin
                        w_timer_nx = r_timer - CNT_W'(1);
                    end
                end
                default: begin
                    w_state_nx = ST_IDLE;
                    w_timer_nx = '0;
                end
            endcase

            if (r_state != ST_IDLE) begin
                // Shadow config lands at a period boundary or on return to IDLE.
                if (r_pend && (w_period_end || (w_state_nx == ST_IDLE))) begin
                    w_act_high_nx = r_pend_high;
                    w_act_low_nx  = r_pend_low;
                    w_act_inv_nx  = r_pend_inv;
                    w_pend_nx     = 1'b0;
                end
                if (w_wr) begin
                    // Burst length only matters at the next start, so it can go
                    // straight to the active register.
                    w_act_bursts_nx = cfg_bursts;
                    if (w_state_nx == ST_IDLE) begin
                        // Channel is leaving the run on this edge: nothing left
                        // to protect, so load active directly.
                        w_act_high_nx = w_cfg_high_c;
                        w_act_low_nx  = w_cfg_low_c;
                        w_act_inv_nx  = cfg_invert;
                    end else begin
                        w_pend_high_nx = w_cfg_high_c;
                        w_pend_low_nx  = w_cfg_low_c;
                        w_pend_inv_nx  = cfg_invert;
                        w_pend_nx      = 1'b1;
                    end
                end
                if (w_period_end) begin
                    w_timer_nx = w_act_high_nx - CNT_W'(1);
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_state      <= ST_IDLE;
                r_timer      <= '0;
                r_pcnt       <= '0;
                r_run_bursts <= '0;
                r_act_high   <= CNT_W'(1);
                r_act_low    <= CNT_W'(1);
                r_act_bursts <= '0;
                r_act_inv    <= 1'b0;
                r_pend_high  <= CNT_W'(1);
                r_pend_low   <= CNT_W'(1);
                r_pend_inv   <= 1'b0;
                r_pend       <= 1'b0;
                r_sig        <= 1'b0;
                r_done       <= 1'b0;
            end else begin
                r_state      <= w_state_nx;
                r_timer      <= w_timer_nx;
                r_pcnt       <= w_pcnt_nx;
                r_run_bursts <= w_run_bursts_nx;
                r_act_high   <= w_act_high_nx;
                r_act_low    <= w_act_low_nx;
                r_act_bursts <= w_act_bursts_nx;
                r_act_inv    <= w_act_inv_nx;
                r_pend_high  <= w_pend_high_nx;
                r_pend_low   <= w_pend_low_nx;
                r_pend_inv   <= w_pend_inv_nx;
                r_pend       <= w_pend_nx;
                // Output level follows the next state and next polarity so the
                // pin changes on the same edge as the state.
                r_sig        <= (w_state_nx == ST_HIGH) ^ w_act_inv_nx;
                r_done       <= w_done_nx;
            end
        end

        assign sig_out[gi] = r_sig;
        assign busy[gi]    = (r_state != ST_IDLE);
        assign done[gi]    = r_done;
    end

endmodule
